mmss_counter: RTL and testbench

//  Minute:second BCD timekeeper for the DE0 one-hour clock (00:00..59:59).

---
 rtl/mmss_counter_pkg.sv | 30 +++
 rtl/mmss_counter_if.sv | 29 ++
 rtl/mmss_counter_bcd_cnt60.sv | 29 ++
 rtl/mmss_counter.sv | 70 +++++++
 tb/tb_mmss_counter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmss_counter_pkg.sv
// Shared definitions for the minute:second timekeeper: BCD limits, digit widths
// and the default board clock. Also reused by the later hour stage.
package mmss_counter_pkg;

  localparam int unsigned UNITS_MAX  = 9;
  localparam int unsigned TENS_MAX   = 5;
  localparam int unsigned UP_W       = 3;
  localparam int unsigned LOW_W      = 4;
  localparam int unsigned DEF_CLK_HZ = 50_000_000;

  // One BCD digit pair (tens:units) of a mod-60 field
  typedef struct packed {
    logic [UP_W-1:0]  up;
    logic [LOW_W-1:0] low;
  } bcd60_t;

  // Successor of a BCD pair in 00..59, wrapping 59 -> 00
  function automatic bcd60_t bcd60_next(input bcd60_t v);
    bcd60_t r;
    r = v;
    if (v.low >= LOW_W'(UNITS_MAX)) begin
      r.low = '0;
      r.up  = (v.up >= UP_W'(TENS_MAX)) ? '0 : v.up + UP_W'(1);
    end else begin
      r.low = v.low + LOW_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mmss_counter_if.sv
// Control and display bundle of the minute:second timekeeper.
// The min_adj signal exists only when MMSS_MIN_ADJ_EN is defined.
interface mmss_counter_if;
  import mmss_counter_pkg::*;

  logic             run;
  logic             clr;
`ifdef MMSS_MIN_ADJ_EN
  logic             min_adj;
`endif
  logic [UP_W-1:0]  sec_up;
  logic [LOW_W-1:0] sec_low;
  logic [UP_W-1:0]  min_up;
  logic [LOW_W-1:0] min_low;
  logic             hour;

`ifdef MMSS_MIN_ADJ_EN
  modport master (output run, clr, min_adj,
                  input  sec_up, sec_low, min_up, min_low, hour);
  modport slave  (input  run, clr, min_adj,
                  output sec_up, sec_low, min_up, min_low, hour);
`else
  modport master (output run, clr,
                  input  sec_up, sec_low, min_up, min_low, hour);
  modport slave  (input  run, clr,
                  output sec_up, sec_low, min_up, min_low, hour);
`endif

endinterface

// File: rtl/mmss_counter_bcd_cnt60.sv
// Mod-60 BCD counter (00..59). carry is combinational: high when inc arrives at 59.
module bcd_cnt60
  import mmss_counter_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [UP_W-1:0]  up,
  output logic [LOW_W-1:0] low,
  output logic             carry
);

  bcd60_t val_q;

  assign up    = val_q.up;
  assign low   = val_q.low;
  assign carry = inc && (val_q.up == UP_W'(TENS_MAX)) && (val_q.low == LOW_W'(UNITS_MAX));

  // Value register: reset/clear to 00, advance one BCD step per inc
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      val_q <= '0;
    end else if (inc) begin
      val_q <= bcd60_next(val_q);
    end
  end

endmodule

// File: rtl/mmss_counter.sv
// Minute:second BCD timekeeper (00:00..59:59) with a 1 Hz prescaler.
// Optional feature: define MMSS_MIN_ADJ_EN to add the min_adj (+1 minute) input.
module mmss_counter
  import mmss_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ = 1
)(
  input logic           CLK,
  input logic           RST,
  mmss_counter_if.slave bus
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PC_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PC_W-1:0] pcnt;
  logic            tick;
  logic            sec_carry;
  logic            min_carry;
  logic            min_inc;

  assign tick = bus.run && (pcnt == PC_W'(DIV - 1));

`ifdef MMSS_MIN_ADJ_EN
  // A coincident adjust and seconds carry still move minutes by one
  assign min_inc = sec_carry | bus.min_adj;
`else
  assign min_inc = sec_carry;
`endif

  // Prescaler: frozen while paused so a resumed second is completed, not restarted
  always_ff @(posedge CLK) begin
    if (RST || bus.clr) begin
      pcnt <= '0;
    end else if (bus.run) begin
      pcnt <= tick ? '0 : pcnt + PC_W'(1);
    end
  end

  bcd_cnt60 u_sec (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (bus.clr),
    .inc   (tick),
    .up    (bus.sec_up),
    .low   (bus.sec_low),
    .carry (sec_carry)
  );

  bcd_cnt60 u_min (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (bus.clr),
    .inc   (min_inc),
    .up    (bus.min_up),
    .low   (bus.min_low),
    .carry (min_carry)
  );

  // Hour pulse: only a seconds-driven 59:59 rollover, lands with the 00:00 display
  always_ff @(posedge CLK) begin
    if (RST || bus.clr) begin
      bus.hour <= 1'b0;
    end else begin
      bus.hour <= sec_carry && min_carry;
    end
  end

endmodule

// File: tb/tb_mmss_counter.sv
// Bench for mmss_counter with CLK_HZ=10, TICK_HZ=1 (one second = 10 cycles).
// Build with MMSS_MIN_ADJ_EN defined to also exercise the minute-adjust input.
module tb_mmss_counter;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mmss_counter_if bus ();

  mmss_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Reference: elapsed time as plain seconds 0..3599 plus a prescaler count
  int m_pc  = 0;
  int m_t   = 0;
  int m_hr  = 0;

  always @(posedge clk) begin
    int mins;
    int secs;
    int tk;
    int sc;
    int adj;
    adj = 0;
`ifdef MMSS_MIN_ADJ_EN
    adj = int'(bus.min_adj);
`endif
    if (rst || bus.clr) begin
      m_pc = 0;
      m_t  = 0;
      m_hr = 0;
    end else begin
      tk   = (bus.run && m_pc == DIV - 1) ? 1 : 0;
      sc   = 0;
      m_hr = 0;
      if (bus.run) m_pc = tk ? 0 : m_pc + 1;
      mins = m_t / 60;
      secs = m_t % 60;
      if (tk != 0) begin
        secs = secs + 1;
        if (secs == 60) begin
          secs = 0;
          mins = mins + 1;
          sc   = 1;
        end
      end
      if (adj != 0 && sc == 0) mins = mins + 1;
      if (sc != 0 && m_t == 3599) m_hr = 1;
      m_t = (mins % 60) * 60 + secs;
    end
  end

  // Per-cycle comparison of every output against the reference
  always @(negedge clk) begin
    int exp_v;
    int act_v;
    exp_v = ((m_t / 600) << 9) | (((m_t / 60) % 10) << 5) |
            (((m_t % 60) / 10) << 2) | 0;
    exp_v = (((m_t / 600) & 7) << 12) | ((((m_t / 60) % 10) & 15) << 8) |
            ((((m_t % 60) / 10) & 7) << 5) | (((m_t % 10) & 15) << 1) | m_hr;
    act_v = (int'(bus.min_up) << 12) | (int'(bus.min_low) << 8) |
            (int'(bus.sec_up) << 5) | (int'(bus.sec_low) << 1) | int'(bus.hour);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle_model t=%0t got %0d%0d:%0d%0d h=%0d want %0d%0d:%0d%0d h=%0d",
               $time, bus.min_up, bus.min_low, bus.sec_up, bus.sec_low, bus.hour,
               m_t / 600, (m_t / 60) % 10, (m_t % 60) / 10, m_t % 10, m_hr);
    end
  end

  // Counts changes of the displayed minutes while enabled
  logic [6:0] min_prev = '0;
  int         min_changes = 0;
  logic       watch = 1'b0;
  always @(negedge clk) begin
    if (watch && {bus.min_up, bus.min_low} != min_prev) min_changes++;
    min_prev <= {bus.min_up, bus.min_low};
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int disp();
    return int'(bus.min_up) * 1000 + int'(bus.min_low) * 100 +
           int'(bus.sec_up) * 10 + int'(bus.sec_low);
  endfunction

  // One clock edge; returns just after the following falling edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.run = 1'b0;
    bus.clr = 1'b0;
`ifdef MMSS_MIN_ADJ_EN
    bus.min_adj = 1'b0;
`endif
    rst = 1'b1;
    cyc(3);
    chk("reset_time", disp(), 0);
    chk("reset_hour", int'(bus.hour), 0);

    // 1: first second completes on the 10th counting edge
    rst     = 1'b0;
    bus.run = 1'b1;
    cyc(9);
    chk("first_sec_edge9", disp(), 0);
    cyc(1);
    chk("first_sec_edge10", disp(), 1);

    // 2: one full minute from zero, minutes advance exactly once
    watch = 1'b1;
    cyc(590);
    watch = 1'b0;
    chk("one_minute", disp(), 100);
    chk("one_minute_carries", min_changes, 1);

    // 3: run up to 59:58, then across the hour
    cyc((3598 - 60) * DIV);
    chk("at_5958", disp(), 5958);
    cyc(10);
    chk("at_5959", disp(), 5959);
    chk("no_hour_5959", int'(bus.hour), 0);
    cyc(10);
    chk("rollover_0000", disp(), 0);
    chk("hour_pulse", int'(bus.hour), 1);
    cyc(1);
    chk("hour_one_cycle", int'(bus.hour), 0);

    // 4: pause mid-second keeps the partial second
    bus.clr = 1'b1;
    cyc(1);
    chk("clr_zero", disp(), 0);
    bus.clr = 1'b0;
    cyc(5);
    bus.run = 1'b0;
    cyc(50);
    chk("paused_sec", disp(), 0);
    bus.run = 1'b1;
    cyc(4);
    chk("resume_9_counting", disp(), 0);
    cyc(1);
    chk("resume_10_counting", disp(), 1);

    // 5: clear on a tick cycle at 12:34
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    cyc(754 * DIV);
    chk("at_1234", disp(), 1234);
    cyc(DIV - 1);
    chk("before_tick_1234", disp(), 1234);
    bus.clr = 1'b1;
    cyc(1);
    chk("clr_on_tick", disp(), 0);
    chk("clr_on_tick_hour", int'(bus.hour), 0);
    bus.clr = 1'b0;
    cyc(DIV - 1);
    chk("after_clr_9", disp(), 0);
    cyc(1);
    chk("after_clr_10", disp(), 1);

`ifdef MMSS_MIN_ADJ_EN
    // 6a: adjust at 59:30 wraps minutes without an hour pulse
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    bus.run = 1'b0;
    bus.min_adj = 1'b1;
    cyc(59);
    bus.min_adj = 1'b0;
    chk("adj_to_5900", disp(), 5900);
    bus.run = 1'b1;
    cyc(30 * DIV);
    bus.run = 1'b0;
    chk("at_5930", disp(), 5930);
    bus.min_adj = 1'b1;
    cyc(1);
    bus.min_adj = 1'b0;
    chk("adj_5930_wrap", disp(), 30);
    chk("adj_wrap_no_hour", int'(bus.hour), 0);
    cyc(1);
    chk("adj_wrap_no_hour_next", int'(bus.hour), 0);

    // 6b: adjust coincident with the minute carry at 05:59
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    bus.min_adj = 1'b1;
    cyc(5);
    bus.min_adj = 1'b0;
    bus.run = 1'b1;
    cyc(59 * DIV + DIV - 1);
    chk("at_0559", disp(), 559);
    bus.min_adj = 1'b1;
    cyc(1);
    bus.min_adj = 1'b0;
    chk("adj_on_carry", disp(), 600);

    // 6c: adjust coincident with the 59:59 rollover keeps the hour pulse
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    bus.run = 1'b0;
    bus.min_adj = 1'b1;
    cyc(59);
    bus.min_adj = 1'b0;
    bus.run = 1'b1;
    cyc(59 * DIV + DIV - 1);
    chk("at_5959_adj", disp(), 5959);
    bus.min_adj = 1'b1;
    cyc(1);
    bus.min_adj = 1'b0;
    chk("adj_hour_time", disp(), 0);
    chk("adj_hour_pulse", int'(bus.hour), 1);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
